// File: rtl/luhn_pkg.sv
// Shared types and helpers for the streaming Luhn engine.
// Holds the FSM state encoding, the mode constants and the mod-10 arithmetic.
package luhn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EVAL,
      RESULT
   } state_t;

   localparam logic MODE_VALIDATE = 1'b0;
   localparam logic MODE_GENERATE = 1'b1;

   // Doubled digit with its two decimal digits summed, so the result is always 0..9.
   function automatic logic [3:0] luhn_dbl(input logic [3:0] d);
      logic [3:0] r;
      case (d)
         4'd0:    r = 4'd0;
         4'd1:    r = 4'd2;
         4'd2:    r = 4'd4;
         4'd3:    r = 4'd6;
         4'd4:    r = 4'd8;
         4'd5:    r = 4'd1;
         4'd6:    r = 4'd3;
         4'd7:    r = 4'd5;
         4'd8:    r = 4'd7;
         4'd9:    r = 4'd9;
         default: r = 4'd0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 5'd10) begin
         s = s - 5'd10;
      end
      return s[3:0];
   endfunction

endpackage

// File: rtl/luhn_stream_checker_if.sv
// Digit stream and result handshake bundle for the Luhn engine.
// The master drives digits and accepts results; the slave is the engine.
interface luhn_stream_checker_if #(
   parameter int MAX_DIGITS = 19
) ();
   localparam int CNT_W = $clog2(MAX_DIGITS + 2);

   logic             mode;
   logic             digit_valid;
   logic             digit_ready;
   logic [3:0]       digit;
   logic             digit_last;
   logic             result_valid;
   logic             result_ready;
   logic             result_ok;
   logic [3:0]       check_digit;
   logic             err_len;
   logic             err_digit;
   logic [CNT_W-1:0] digit_count;
   logic             busy;

   modport master (
      output mode, digit_valid, digit, digit_last, result_ready,
      input  digit_ready, result_valid, result_ok, check_digit,
             err_len, err_digit, digit_count, busy
   );

   modport slave (
      input  mode, digit_valid, digit, digit_last, result_ready,
      output digit_ready, result_valid, result_ok, check_digit,
             err_len, err_digit, digit_count, busy
   );

endinterface

// File: rtl/luhn_dual_acc.sv
// Two mod-10 Luhn accumulators, one per possible parity of the final string length.
// Both are kept because which digits are doubled is only known once the last digit arrives.
module luhn_dual_acc
   import luhn_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       en,
   input  logic [3:0] digit,
   input  logic       sel_odd_len,
   output logic [3:0] sum
);

   logic [3:0] acc_e_q, acc_e_d;
   logic [3:0] acc_o_q, acc_o_d;
   logic       odd_idx_q, odd_idx_d;
   logic [3:0] base_e, base_o;
   logic       base_odd;

   // acc_e doubles even left-indices, acc_o doubles odd ones; clear restarts at index 0.
   always_comb begin
      base_e    = clear ? 4'd0 : acc_e_q;
      base_o    = clear ? 4'd0 : acc_o_q;
      base_odd  = clear ? 1'b0 : odd_idx_q;
      acc_e_d   = base_e;
      acc_o_d   = base_o;
      odd_idx_d = base_odd;
      if (en) begin
         if (base_odd) begin
            acc_e_d = add_mod10(base_e, digit);
            acc_o_d = add_mod10(base_o, luhn_dbl(digit));
         end else begin
            acc_e_d = add_mod10(base_e, luhn_dbl(digit));
            acc_o_d = add_mod10(base_o, digit);
         end
         odd_idx_d = ~base_odd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_e_q   <= 4'd0;
         acc_o_q   <= 4'd0;
         odd_idx_q <= 1'b0;
      end else begin
         acc_e_q   <= acc_e_d;
         acc_o_q   <= acc_o_d;
         odd_idx_q <= odd_idx_d;
      end
   end

   assign sum = sel_odd_len ? acc_o_q : acc_e_q;

endmodule

// File: rtl/luhn_stream_checker.sv
// Streaming Luhn validate/generate engine: one MSD-first digit string in, one result out.
// Owns the FSM, digit counter, sticky error flags and the registered result fields.
module luhn_stream_checker
   import luhn_pkg::*;
#(
   parameter int MAX_DIGITS = 19,
   parameter int MIN_DIGITS = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   luhn_stream_checker_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_DIGITS + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_DIGITS);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_DIGITS + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   logic             err_digit_q, err_digit_d;
   logic             err_len_q, err_len_d;
   logic             result_ok_q, result_ok_d;
   logic [3:0]       check_digit_q, check_digit_d;

   logic       digit_ready;
   logic       beat;
   logic       first;
   logic       bad_digit;
   logic       acc_en;
   logic [3:0] acc_digit;
   logic       sel_odd_len;
   logic [3:0] acc_sum;
   logic       any_err;

   assign digit_ready = (state_q == IDLE) || (state_q == ACCUM);
   assign beat        = bus.digit_valid && digit_ready;
   assign first       = beat && (state_q == IDLE);
   assign bad_digit   = bus.digit > 4'd9;
   assign acc_digit   = bad_digit ? 4'd0 : bus.digit;
   assign acc_en      = beat && (first || (count_q < CNT_MAX));
   // The undoubled position is the last digit when validating, the appended one when generating.
   assign sel_odd_len = count_q[0] ^ (mode_q == MODE_GENERATE);

   luhn_dual_acc u_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (first),
      .en          (acc_en),
      .digit       (acc_digit),
      .sel_odd_len (sel_odd_len),
      .sum         (acc_sum)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      mode_d        = mode_q;
      err_digit_d   = err_digit_q;
      err_len_d     = err_len_q;
      result_ok_d   = result_ok_q;
      check_digit_d = check_digit_q;
      any_err       = 1'b0;
      case (state_q)
         IDLE: begin
            if (beat) begin
               count_d     = CNT_W'(1);
               mode_d      = bus.mode;
               err_digit_d = bad_digit;
               state_d     = bus.digit_last ? EVAL : ACCUM;
            end
         end
         ACCUM: begin
            if (beat) begin
               if (count_q != CNT_SAT) begin
                  count_d = count_q + CNT_W'(1);
               end
               err_digit_d = err_digit_q | bad_digit;
               if (bus.digit_last) begin
                  state_d = EVAL;
               end
            end
         end
         EVAL: begin
            err_len_d = (count_q < CNT_MIN) || (count_q > CNT_MAX);
            any_err   = err_len_d || err_digit_q;
            if (any_err) begin
               result_ok_d   = 1'b0;
               check_digit_d = 4'd0;
            end else if (mode_q == MODE_VALIDATE) begin
               result_ok_d   = (acc_sum == 4'd0);
               check_digit_d = 4'd0;
            end else begin
               result_ok_d   = 1'b1;
               check_digit_d = (acc_sum == 4'd0) ? 4'd0 : (4'd10 - acc_sum);
            end
            state_d = RESULT;
         end
         RESULT: begin
            if (bus.result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         count_q       <= '0;
         mode_q        <= MODE_VALIDATE;
         err_digit_q   <= 1'b0;
         err_len_q     <= 1'b0;
         result_ok_q   <= 1'b0;
         check_digit_q <= 4'd0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         mode_q        <= mode_d;
         err_digit_q   <= err_digit_d;
         err_len_q     <= err_len_d;
         result_ok_q   <= result_ok_d;
         check_digit_q <= check_digit_d;
      end
   end

   assign bus.digit_ready  = digit_ready;
   assign bus.result_valid = (state_q == RESULT);
   assign bus.result_ok    = result_ok_q;
   assign bus.check_digit  = check_digit_q;
   assign bus.err_len      = err_len_q;
   assign bus.err_digit    = err_digit_q;
   assign bus.digit_count  = count_q;
   assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_luhn_stream_checker.sv
// Directed and randomised checks of the streaming Luhn engine against hand-worked results
// and a right-to-left Luhn reference model.
module tb_luhn_stream_checker;

   logic clk;
   logic rst_n;

   luhn_stream_checker_if #(.MAX_DIGITS(19)) bus ();

   luhn_stream_checker #(
      .MAX_DIGITS (19),
      .MIN_DIGITS (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks;
   int errors;
   logic [3:0] str_buf [0:31];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic loadHex(input logic [79:0] v, input int len);
      for (int i = 0; i < len; i++) begin
         str_buf[i] = v[4*(len-1-i) +: 4];
      end
   endtask

   // Later beats drive the opposite mode so a missing mode latch shows up.
   task automatic applyStimulus(input int len, input logic md, input bit gaps);
      int waited;
      for (int i = 0; i < len; i++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            bus.digit_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus.digit_valid = 1'b1;
         bus.digit       = str_buf[i];
         bus.digit_last  = (i == len - 1);
         bus.mode        = (i == 0) ? md : ~md;
         waited = 0;
         while (!bus.digit_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
         end
         if (!bus.digit_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      bus.digit_valid = 1'b0;
      bus.digit_last  = 1'b0;
   endtask

   task automatic waitResult(input string tag);
      int waited;
      waited = 0;
      while (!bus.result_valid && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
   endtask

   task automatic handshake();
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
   endtask

   task automatic checkResult(input string tag, input logic ok, input logic [3:0] chk,
                              input logic elen, input logic edig, input int cnt);
      waitResult(tag);
      checkOutput({tag, "_ok"},    32'(bus.result_ok),   32'(ok));
      checkOutput({tag, "_chk"},   32'(bus.check_digit), 32'(chk));
      checkOutput({tag, "_elen"},  32'(bus.err_len),     32'(elen));
      checkOutput({tag, "_edig"},  32'(bus.err_digit),   32'(edig));
      checkOutput({tag, "_count"}, 32'(bus.digit_count), 32'(cnt));
      handshake();
   endtask

   // Position counted from the undoubled rightmost digit; odd distances are doubled.
   function automatic int refSum(input int len, input bit gen);
      int s;
      int pos;
      int d;
      s = 0;
      for (int i = 0; i < len; i++) begin
         d   = int'(str_buf[i]);
         pos = gen ? (len - i) : (len - 1 - i);
         if (pos % 2 == 1) s += (2 * d > 9) ? (2 * d - 9) : (2 * d);
         else              s += d;
      end
      return s % 10;
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int len;
      bit md;
      int s;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.mode = 1'b0;
      bus.digit_valid = 1'b0;
      bus.digit = 4'd0;
      bus.digit_last = 1'b0;
      bus.result_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready", 32'(bus.digit_ready),  32'd1);
      checkOutput("rst_valid", 32'(bus.result_valid), 32'd0);
      checkOutput("rst_busy",  32'(bus.busy),         32'd0);
      checkOutput("rst_count", 32'(bus.digit_count),  32'd0);
      checkOutput("rst_ok",    32'(bus.result_ok),    32'd0);
      checkOutput("rst_errs",  32'({bus.err_len, bus.err_digit}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] validate 79927398713");
      loadHex(80'h79927398713, 11);
      applyStimulus(11, 1'b0, 1'b0);
      checkOutput("lat_valid", 32'(bus.result_valid), 32'd0);
      checkOutput("lat_busy",  32'(bus.busy),         32'd1);
      checkOutput("lat_ready", 32'(bus.digit_ready),  32'd0);
      checkResult("v11", 1'b1, 4'd0, 1'b0, 1'b0, 11);

      loadHex(80'h79927398710, 11);
      applyStimulus(11, 1'b0, 1'b0);
      checkResult("v11bad", 1'b0, 4'd0, 1'b0, 1'b0, 11);

      loadHex(80'h7992739871, 10);
      applyStimulus(10, 1'b1, 1'b0);
      checkResult("gen10", 1'b1, 4'd3, 1'b0, 1'b0, 10);

      $display("[TB] length boundaries");
      for (int i = 0; i < 20; i++) str_buf[i] = 4'd0;
      applyStimulus(20, 1'b0, 1'b0);
      checkResult("len20", 1'b0, 4'd0, 1'b1, 1'b0, 20);
      applyStimulus(19, 1'b0, 1'b0);
      checkResult("len19", 1'b1, 4'd0, 1'b0, 1'b0, 19);
      applyStimulus(1, 1'b0, 1'b0);
      checkResult("len1", 1'b0, 4'd0, 1'b1, 1'b0, 1);
      loadHex(80'h18, 2);
      applyStimulus(2, 1'b0, 1'b0);
      checkResult("len2", 1'b1, 4'd0, 1'b0, 1'b0, 2);

      $display("[TB] illegal digit");
      loadHex(80'h79A2, 4);
      applyStimulus(4, 1'b0, 1'b0);
      checkResult("edig", 1'b0, 4'd0, 1'b0, 1'b1, 4);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("edig_once", 32'(bus.result_valid), 32'd0);
      loadHex(80'h79A2, 4);
      applyStimulus(4, 1'b1, 1'b0);
      checkResult("edig_gen", 1'b0, 4'd0, 1'b0, 1'b1, 4);

      $display("[TB] result backpressure");
      loadHex(80'h79927398713, 11);
      applyStimulus(11, 1'b0, 1'b0);
      waitResult("hold");
      for (int i = 0; i < 5; i++) begin
         bus.digit_valid = 1'b1;
         bus.digit = 4'd5;
         @(posedge clk); #1;
         checkOutput("hold_valid", 32'(bus.result_valid), 32'd1);
         checkOutput("hold_ok",    32'(bus.result_ok),    32'd1);
         checkOutput("hold_count", 32'(bus.digit_count),  32'd11);
         checkOutput("hold_ready", 32'(bus.digit_ready),  32'd0);
      end
      bus.digit_valid = 1'b0;
      handshake();
      checkOutput("b2b_ready", 32'(bus.digit_ready), 32'd1);
      loadHex(80'h18, 2);
      applyStimulus(2, 1'b0, 1'b0);
      checkResult("b2b", 1'b1, 4'd0, 1'b0, 1'b0, 2);

      $display("[TB] reset mid-string");
      loadHex(80'h123456, 6);
      for (int i = 0; i < 6; i++) begin
         bus.digit_valid = 1'b1;
         bus.digit = str_buf[i];
         bus.digit_last = 1'b0;
         bus.mode = 1'b1;
         @(posedge clk); #1;
      end
      bus.digit_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("mrst_busy",  32'(bus.busy),         32'd0);
      checkOutput("mrst_ready", 32'(bus.digit_ready),  32'd1);
      checkOutput("mrst_valid", 32'(bus.result_valid), 32'd0);
      checkOutput("mrst_count", 32'(bus.digit_count),  32'd0);
      loadHex(80'h79927398713, 11);
      applyStimulus(11, 1'b0, 1'b0);
      checkResult("mrst_v11", 1'b1, 4'd0, 1'b0, 1'b0, 11);

      $display("[TB] random strings");
      for (int n = 0; n < 12; n++) begin
         len = int'($urandom_range(2, 19));
         md  = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) str_buf[i] = 4'($urandom_range(0, 9));
         applyStimulus(len, md, 1'b1);
         s = refSum(len, md);
         if (md) checkResult("rnd_gen", 1'b1, 4'((10 - s) % 10), 1'b0, 1'b0, len);
         else    checkResult("rnd_val", (s == 0), 4'd0, 1'b0, 1'b0, len);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
